// File: rtl/mux_scan_param.sv
// mux_scan_param: parametrised CH-channel, W-bit registered multiplexer with
// a direct-select mode and a round-robin auto-scan mode.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   i          packed channel data, channel k at i[k*W +: W]
//   s          direct-mode select; scan start channel on scan entry
//   mode       0 = direct, 1 = auto-scan
//   en         per-channel enable mask (scan mode only)
//   dwell      cycles spent on each channel in scan mode (0 behaves as 1)
//   o          registered selected data
//   o_valid    o/o_ch carry a legal channel's data
//   o_ch       channel index currently driving o
//   scan_wrap  one-cycle pulse when the scan pointer wraps to a lower-or-equal index
module mux_scan_param #(
  parameter int CH   = 16,
  parameter int W    = 8,
  parameter int SELW = 4,
  parameter int DWW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*W-1:0] i,
  input  logic [SELW-1:0] s,
  input  logic            mode,
  input  logic [CH-1:0]   en,
  input  logic [DWW-1:0]  dwell,
  output logic [W-1:0]    o,
  output logic            o_valid,
  output logic [SELW-1:0] o_ch,
  output logic            scan_wrap
);

  logic [W-1:0] ch_data [CH];

  for (genvar k = 0; k < CH; k++) begin : g_unpack
    assign ch_data[k] = i[k*W +: W];
  end

  // Loop-based lookups keep every index in range even when CH is not a
  // power of two and the select can exceed the last channel.
  function automatic logic idx_legal(input logic [SELW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int j = 0; j < CH; j++)
      if (int'(idx) == j) r = 1'b1;
    return r;
  endfunction

  function automatic logic en_at(input logic [CH-1:0] m, input logic [SELW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int j = 0; j < CH; j++)
      if (int'(idx) == j) r = m[j];
    return r;
  endfunction

  function automatic logic [W-1:0] pick(input logic [SELW-1:0] idx);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < CH; j++)
      if (int'(idx) == j) r = ch_data[j];
    return r;
  endfunction

  // Circular priority search: lowest enabled index above 'from' (or at it
  // when incl is set), otherwise the lowest enabled index overall (wrap).
  // The caller handles the all-disabled case separately.
  function automatic logic [SELW-1:0] find_en(input logic [CH-1:0] m,
                                              input logic [SELW-1:0] from,
                                              input logic incl);
    logic [SELW-1:0] hi, lo;
    logic            hi_ok;
    hi    = '0;
    lo    = '0;
    hi_ok = 1'b0;
    for (int j = CH - 1; j >= 0; j--) begin
      if (m[j]) begin
        lo = SELW'(j);
        if (j > int'(from) || (incl && j == int'(from))) begin
          hi    = SELW'(j);
          hi_ok = 1'b1;
        end
      end
    end
    return hi_ok ? hi : lo;
  endfunction

  logic [SELW-1:0] ptr, ptr_n;
  logic [DWW-1:0]  dcnt, dcnt_n;
  logic            mode_q;
  logic [W-1:0]    o_n;
  logic            o_valid_n;
  logic [SELW-1:0] o_ch_n;
  logic            wrap_n;

  logic [DWW-1:0]  dlim;
  logic [SELW-1:0] nxt, start;
  logic            any_en;

  // dlim is the last dcnt value of a dwell; dcnt at or past it advances,
  // so shrinking dwell mid-dwell takes effect immediately.
  assign dlim   = (dwell == '0) ? '0 : dwell - DWW'(1);
  assign nxt    = find_en(en, ptr, 1'b0);
  assign start  = find_en(en, s, 1'b1);
  assign any_en = |en;

  always_comb begin
    ptr_n     = ptr;
    dcnt_n    = dcnt;
    o_n       = o;
    o_valid_n = o_valid;
    o_ch_n    = o_ch;
    wrap_n    = 1'b0;
    if (!mode) begin
      dcnt_n = '0;
      o_ch_n = s;
      if (idx_legal(s)) begin
        o_n       = pick(s);
        o_valid_n = 1'b1;
      end else begin
        o_n       = '0;
        o_valid_n = 1'b0;
      end
    end else if (!mode_q) begin
      // Scan entry: position on the first enabled channel at or after s.
      ptr_n     = any_en ? start : s;
      dcnt_n    = '0;
      o_valid_n = 1'b0;
    end else if (!any_en) begin
      o_n       = '0;
      o_valid_n = 1'b0;
    end else if (!en_at(en, ptr)) begin
      // Current channel was disabled mid-dwell: skip ahead without output.
      o_n       = '0;
      o_valid_n = 1'b0;
      ptr_n     = nxt;
      dcnt_n    = '0;
      wrap_n    = (nxt <= ptr);
    end else begin
      o_n       = pick(ptr);
      o_ch_n    = ptr;
      o_valid_n = 1'b1;
      if (dcnt >= dlim) begin
        dcnt_n = '0;
        ptr_n  = nxt;
        wrap_n = (nxt <= ptr);
      end else begin
        dcnt_n = dcnt + DWW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      dcnt      <= '0;
      mode_q    <= 1'b0;
      o         <= '0;
      o_valid   <= 1'b0;
      o_ch      <= '0;
      scan_wrap <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      dcnt      <= dcnt_n;
      mode_q    <= mode;
      o         <= o_n;
      o_valid   <= o_valid_n;
      o_ch      <= o_ch_n;
      scan_wrap <= wrap_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_param.sv
module tb_mux_scan_param;

  localparam int CH = 16;
  localparam int W  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [CH*W-1:0] i;
  logic [3:0]     s;
  logic           mode;
  logic [CH-1:0]  en;
  logic [7:0]     dwell;
  logic [W-1:0]   o;
  logic           o_valid;
  logic [3:0]     o_ch;
  logic           scan_wrap;

  // Second instance: 10 channels, direct mode only.
  logic [3:0]     s2;
  logic [W-1:0]   o2;
  logic           o2_valid;
  logic [3:0]     o2_ch;
  logic           wrap2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_scan_param #(.CH(16), .W(8), .SELW(4), .DWW(8)) dut (
    .clk(clk), .rst(rst), .i(i), .s(s), .mode(mode), .en(en), .dwell(dwell),
    .o(o), .o_valid(o_valid), .o_ch(o_ch), .scan_wrap(scan_wrap));

  mux_scan_param #(.CH(10), .W(8), .SELW(4), .DWW(8)) dut10 (
    .clk(clk), .rst(rst), .i(i[10*W-1:0]), .s(s2), .mode(1'b0), .en(10'h3FF),
    .dwell(8'd0), .o(o2), .o_valid(o2_valid), .o_ch(o2_ch), .scan_wrap(wrap2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int m_ptr, m_cnt;
  bit m_prev;
  bit e_valid, e_wrap, c_o, c_ch, c_wrap;
  int e_o, e_ch;

  function automatic int dat(input int k);
    return int'(i[k*W +: W]);
  endfunction

  function automatic int first_from(input int st, input logic [CH-1:0] m);
    for (int k = 0; k < CH; k++)
      if (m[(st + k) % CH]) return (st + k) % CH;
    return -1;
  endfunction

  function automatic int next_after(input int p, input logic [CH-1:0] m);
    for (int k = 1; k <= CH; k++)
      if (m[(p + k) % CH]) return (p + k) % CH;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_prev = 0;
  endtask

  task automatic model_step();
    int n, d;
    c_o = 0; c_ch = 0; c_wrap = 1; e_wrap = 0; e_o = 0; e_ch = 0; e_valid = 0;
    if (!mode) begin
      e_valid = 1; e_o = dat(int'(s)); e_ch = int'(s); c_o = 1; c_ch = 1; m_cnt = 0;
    end else if (!m_prev) begin
      m_ptr = (en != 0) ? first_from(int'(s), en) : int'(s);
      m_cnt = 0; c_wrap = 0;
    end else if (en == 0) begin
      c_o = 1;
    end else if (!en[m_ptr]) begin
      n = next_after(m_ptr, en);
      e_wrap = (n <= m_ptr); m_ptr = n; m_cnt = 0;
    end else begin
      e_valid = 1; e_o = dat(m_ptr); e_ch = m_ptr; c_o = 1; c_ch = 1;
      d = (dwell == 0) ? 1 : int'(dwell);
      if (m_cnt + 1 >= d) begin
        n = next_after(m_ptr, en);
        e_wrap = (n <= m_ptr); m_ptr = n; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    m_prev = mode;
  endtask

  task automatic cycle();
    int s2v;
    s2v = int'(s2);
    @(posedge clk);
    model_step();
    #1;
    chk("o_valid", 32'(o_valid), 32'(e_valid));
    if (c_o)    chk("o", 32'(o), 32'(e_o));
    if (c_ch)   chk("o_ch", 32'(o_ch), 32'(e_ch));
    if (c_wrap) chk("scan_wrap", 32'(scan_wrap), 32'(e_wrap));
    chk("ch10_valid", 32'(o2_valid), 32'(s2v < 10));
    chk("ch10_o", 32'(o2), (s2v < 10) ? 32'(dat(s2v)) : 32'd0);
    chk("ch10_o_ch", 32'(o2_ch), 32'(s2v));
    chk("ch10_wrap", 32'(wrap2), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_o"}, 32'(o), 32'd0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_o_ch"}, 32'(o_ch), 32'd0);
    chk({tag, "_wrap"}, 32'(scan_wrap), 32'd0);
  endtask

  initial begin
    int seq [10];
    int guard;
    seq = '{0, 0, 0, 4, 4, 4, 8, 8, 8, 0};

    // Asynchronous reset with scan mode requested.
    rst = 1; mode = 1; s = 4'd3; s2 = 4'd0; en = 16'hFFFF; dwell = 8'd2;
    for (int k = 0; k < CH; k++) i[k*W +: W] = 8'($urandom);
    #2;
    chk_reset_outs("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst_held");
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    chk_reset_outs("rst_release");
    mode = 0;

    // Direct sweep with i[k] = 0x10 + k; 10-channel instance sweeps too.
    for (int k = 0; k < CH; k++) i[k*W +: W] = 8'(8'h10 + k);
    for (int k = 0; k < 16; k++) begin
      s = 4'(k); s2 = 4'(k);
      cycle();
      chk("direct_o", 32'(o), 32'(8'h10 + k));
    end
    s2 = 4'd12; cycle();
    chk("np2_s12_valid", 32'(o2_valid), 32'd0);
    chk("np2_s12_o_ch", 32'(o2_ch), 32'd12);
    s2 = 4'd9; cycle();
    chk("np2_s9_o", 32'(o2), 32'h19);

    // Scan with mask 0x0111, dwell 3, start 0.
    en = 16'h0111; dwell = 8'd3; s = 4'd0;
    mode = 1; cycle();
    chk("entry_valid", 32'(o_valid), 32'd0);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("scan_seq_ch", 32'(o_ch), 32'(seq[k]));
      chk("scan_seq_wrap", 32'(scan_wrap), 32'(k == 8));
    end

    // Single channel, dwell 0.
    mode = 0; cycle();
    en = 16'h0020; dwell = 8'd0; mode = 1; cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("single_ch", 32'(o_ch), 32'd5);
      chk("single_wrap", 32'(scan_wrap), 32'd1);
    end

    // Mid-dwell disable, then all disabled, then restore.
    mode = 0; cycle();
    en = 16'h0111; dwell = 8'd3; s = 4'd0; mode = 1; cycle();
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (!(e_valid && e_ch == 4) && guard < 20);
    chk("reach_ch4", 32'(guard < 20), 32'd1);
    en = 16'h0101; cycle();
    chk("disable_valid", 32'(o_valid), 32'd0);
    cycle();
    chk("after_disable_ch", 32'(o_ch), 32'd8);
    chk("after_disable_valid", 32'(o_valid), 32'd1);
    en = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("alloff_valid", 32'(o_valid), 32'd0);
      chk("alloff_o", 32'(o), 32'd0);
    end
    en = 16'h0111; cycle();
    chk("resume_ch", 32'(o_ch), 32'd8);

    // Randomised traffic with occasional async reset pulses.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      s  = 4'($urandom);
      s2 = 4'($urandom);
      case ($urandom_range(0, 5))
        0: en = 16'h0;
        1: en = 16'(1 << $urandom_range(0, 15));
        2: en = 16'($urandom) & 16'($urandom);
        default: if ($urandom_range(0, 3) == 0) en = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) dwell = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < CH; k++) i[k*W +: W] = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1; #1;
        chk_reset_outs("rst_pulse");
        model_reset();
        @(negedge clk);
        rst = 0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
